// File: rtl/ascon_feeder.sv
// Host-side sequencer for the ASCON core: start pulse, A/P1..P3 hand-over, ciphertext buffer, tag capture.
// Optional phase watchdog compiled in with `define ASCON_FEEDER_TIMEOUT_EN.
module ascon_feeder #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clock_i,
    input  logic          resetb_i,
    input  logic          go_i,
    input  logic          in_valid_i,
    input  logic [63:0]   in_data_i,
    output logic          in_ready_o,
    output logic          start_o,
    output logic          data_valid_o,
    output logic [63:0]   data_o,
    input  logic          end_initialisation_i,
    input  logic          end_associate_i,
    input  logic          end_cipher1_i,
    input  logic          end_cipher2_i,
    input  logic          end_i,
    input  logic          cipher_valid_i,
    input  logic [63:0]   cipher_i,
    input  logic [127:0]  tag_i,
    output logic          cipher_valid_o,
    output logic [63:0]   cipher_o,
    input  logic          cipher_ready_i,
    output logic [127:0]  tag_o,
    output logic [1:0]    blk_idx_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          error_o
);
    // state     | meaning
    // IDLE      | waiting for go_i
    // START     | start_o pulse to the core
    // WAIT_INIT | waiting for end_initialisation_i
    // REQ       | offering in_ready_o for the next block
    // PULSE     | data_valid_o pulse with the accepted block
    // WAIT_BLK  | waiting for the phase flag of the current block
    // DONE      | done_o pulse, tag captured
    // ERR       | watchdog expired (watchdog build only)
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT_INIT, S_REQ, S_PULSE, S_WAIT_BLK, S_DONE
`ifdef ASCON_FEEDER_TIMEOUT_EN
        , S_ERR
`endif
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     blk_idx_q, blk_idx_d;
    logic [63:0]    data_q, data_d;
    logic [127:0]   tag_q, tag_d;
    logic           cbuf_valid_q, cbuf_valid_d;
    logic [63:0]    cbuf_q, cbuf_d;
    logic           flag_hit;
    logic           accept;
    logic           timeout;

    always_comb begin
        flag_hit = 1'b0;
        case (blk_idx_q)
            2'd0:    flag_hit = end_associate_i;
            2'd1:    flag_hit = end_cipher1_i;
            2'd2:    flag_hit = end_cipher2_i;
            default: flag_hit = end_i;
        endcase
    end

    assign accept = in_valid_i & in_ready_o;

`ifdef ASCON_FEEDER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          waiting;

    // Counter restarts from zero on every entry into a wait state.
    assign waiting = (state_q == S_WAIT_INIT) || (state_q == S_WAIT_BLK);
    assign cnt_d   = waiting ? CW'(cnt_q + 1'b1) : '0;
    assign timeout = cnt_q == CW'(TIMEOUT_CYCLES);
    assign error_o = err_q;
`else
    assign timeout = 1'b0;
    assign error_o = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        blk_idx_d = blk_idx_q;
        data_d    = data_q;
        tag_d     = tag_q;
`ifdef ASCON_FEEDER_TIMEOUT_EN
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: if (go_i) begin
                blk_idx_d = 2'd0;
                tag_d     = '0;
`ifdef ASCON_FEEDER_TIMEOUT_EN
                err_d     = 1'b0;
`endif
                state_d   = S_START;
            end
            S_START: state_d = S_WAIT_INIT;
            S_WAIT_INIT: begin
                if (end_initialisation_i) begin
                    state_d = S_REQ;
                end else if (timeout) begin
`ifdef ASCON_FEEDER_TIMEOUT_EN
                    err_d   = 1'b1;
                    state_d = S_ERR;
`endif
                end
            end
            S_REQ: if (accept) begin
                data_d  = in_data_i;
                state_d = S_PULSE;
            end
            S_PULSE: state_d = S_WAIT_BLK;
            S_WAIT_BLK: begin
                if (flag_hit) begin
                    if (blk_idx_q == 2'd3) begin
                        tag_d   = tag_i;
                        state_d = S_DONE;
                    end else begin
                        blk_idx_d = blk_idx_q + 2'd1;
                        state_d   = S_REQ;
                    end
                end else if (timeout) begin
`ifdef ASCON_FEEDER_TIMEOUT_EN
                    err_d   = 1'b1;
                    state_d = S_ERR;
`endif
                end
            end
            S_DONE: state_d = S_IDLE;
`ifdef ASCON_FEEDER_TIMEOUT_EN
            S_ERR: if (go_i) begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Single-entry ciphertext buffer; a fill in the pop cycle wins.
    always_comb begin
        cbuf_valid_d = cbuf_valid_q;
        cbuf_d       = cbuf_q;
        if (cbuf_valid_q && cipher_ready_i) cbuf_valid_d = 1'b0;
        if (cipher_valid_i && (state_q != S_IDLE)) begin
            cbuf_valid_d = 1'b1;
            cbuf_d       = cipher_i;
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q      <= S_IDLE;
            blk_idx_q    <= 2'd0;
            data_q       <= '0;
            tag_q        <= '0;
            cbuf_valid_q <= 1'b0;
            cbuf_q       <= '0;
        end else begin
            state_q      <= state_d;
            blk_idx_q    <= blk_idx_d;
            data_q       <= data_d;
            tag_q        <= tag_d;
            cbuf_valid_q <= cbuf_valid_d;
            cbuf_q       <= cbuf_d;
        end
    end

`ifdef ASCON_FEEDER_TIMEOUT_EN
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

    // The core cannot stall, so no block is offered while ciphertext is pending.
    assign in_ready_o     = (state_q == S_REQ) && !cbuf_valid_q;
    assign start_o        = state_q == S_START;
    assign data_valid_o   = state_q == S_PULSE;
    assign done_o         = state_q == S_DONE;
    assign busy_o         = state_q != S_IDLE;
    assign data_o         = data_q;
    assign tag_o          = tag_q;
    assign blk_idx_o      = blk_idx_q;
    assign cipher_valid_o = cbuf_valid_q;
    assign cipher_o       = cbuf_q;

endmodule

// File: tb/tb_ascon_feeder.sv
// Directed bench for ascon_feeder: plays the core and upstream, scoreboards blocks and ciphertext.
module tb_ascon_feeder;
    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          go_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic [63:0]   in_data_i = '0;
    logic          in_ready_o;
    logic          start_o;
    logic          data_valid_o;
    logic [63:0]   data_o;
    logic          end_init = 1'b0, end_assoc = 1'b0, end_c1 = 1'b0, end_c2 = 1'b0, end_fin = 1'b0;
    logic          cipher_valid_i = 1'b0;
    logic [63:0]   cipher_i = '0;
    logic [127:0]  tag_i = '0;
    logic          cipher_valid_o;
    logic [63:0]   cipher_o;
    logic          cipher_ready_i = 1'b1;
    logic [127:0]  tag_o;
    logic [1:0]    blk_idx_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;

    int errs = 0;
    int checks = 0;
    int start_cnt = 0, dv_cnt = 0, done_cnt = 0;
    logic [63:0] exp_blk_q[$];
    logic [63:0] exp_cip_q[$];

    ascon_feeder #(.TIMEOUT_CYCLES(64)) dut (
        .clock_i(clk), .resetb_i(rst_n), .go_i(go_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
        .start_o(start_o), .data_valid_o(data_valid_o), .data_o(data_o),
        .end_initialisation_i(end_init), .end_associate_i(end_assoc),
        .end_cipher1_i(end_c1), .end_cipher2_i(end_c2), .end_i(end_fin),
        .cipher_valid_i(cipher_valid_i), .cipher_i(cipher_i), .tag_i(tag_i),
        .cipher_valid_o(cipher_valid_o), .cipher_o(cipher_o), .cipher_ready_i(cipher_ready_i),
        .tag_o(tag_o), .blk_idx_o(blk_idx_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard side: pop expectations when the DUT presents a block or pops ciphertext.
    always @(negedge clk) begin
        if (rst_n) begin
            if (start_o) start_cnt++;
            if (done_o) done_cnt++;
            if (data_valid_o) begin
                dv_cnt++;
                if (exp_blk_q.size() == 0) begin
                    checks++; errs++;
                    $error("FAIL dv_unexpected observed=%h expected=none", data_o);
                end else chk("dv_data", {64'h0, data_o}, {64'h0, exp_blk_q.pop_front()});
            end
            if (cipher_valid_o && cipher_ready_i) begin
                if (exp_cip_q.size() == 0) begin
                    checks++; errs++;
                    $error("FAIL cipher_unexpected observed=%h expected=none", cipher_o);
                end else chk("cipher_pop", {64'h0, cipher_o}, {64'h0, exp_cip_q.pop_front()});
            end
        end
    end

    task automatic send_block(input logic [63:0] d);
        int n = 0;
        in_data_i = d;
        in_valid_i = 1'b1;
        exp_blk_q.push_back(d);
        while (!in_ready_o && n < 50) begin
            tick(1);
            n++;
        end
        chk("ready_wait", {127'h0, n < 50}, 128'h1);
        tick(1);
        in_valid_i = 1'b0;
        chk("dv_after_accept", {127'h0, data_valid_o}, 128'h1);
    endtask

    task automatic pulse_flag(input int idx);
        case (idx)
            0: end_assoc = 1'b1;
            1: end_c1 = 1'b1;
            2: end_c2 = 1'b1;
            3: end_fin = 1'b1;
            default: end_init = 1'b1;
        endcase
        tick(1);
        {end_init, end_assoc, end_c1, end_c2, end_fin} = '0;
    endtask

    task automatic go_pulse();
        go_i = 1'b1;
        tick(1);
        go_i = 1'b0;
    endtask

    task automatic full_run(input logic [63:0] a, input logic [127:0] tag);
        logic [63:0] blks [4];
        int s0, d0, n0;
        blks[0] = a; blks[1] = 64'h1; blks[2] = 64'h2; blks[3] = 64'h3;
        s0 = start_cnt; d0 = dv_cnt; n0 = done_cnt;
        go_pulse();
        chk("busy_rise", {127'h0, busy_o}, 128'h1);
        chk("start_c1", {127'h0, start_o}, 128'h1);
        tick(1);
        chk("start_c2", {127'h0, start_o}, 128'h0);
        tick(10);
        pulse_flag(4);
        for (int i = 0; i < 4; i++) begin
            chk("ready_after_flag", {127'h0, in_ready_o}, 128'h1);
            chk("blk_idx", {126'h0, blk_idx_o}, 128'(i));
            send_block(blks[i]);
            tick(11);
            if (i == 3) tag_i = tag;
            pulse_flag(i);
        end
        chk("done_pulse", {127'h0, done_o}, 128'h1);
        chk("tag_cap", tag_o, tag);
        tick(1);
        chk("done_low", {127'h0, done_o}, 128'h0);
        tick(1);
        chk("busy_fall", {127'h0, busy_o}, 128'h0);
        chk("tag_hold", tag_o, tag);
        chk("start_count", 128'(start_cnt - s0), 128'd1);
        chk("dv_count", 128'(dv_cnt - d0), 128'd4);
        chk("done_count", 128'(done_cnt - n0), 128'd1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        tick(2);
        chk("rst_busy", {127'h0, busy_o}, 128'h0);
        chk("rst_ready", {127'h0, in_ready_o}, 128'h0);
        chk("rst_start", {127'h0, start_o}, 128'h0);
        chk("rst_tag", tag_o, 128'h0);
        chk("rst_data", {64'h0, data_o}, 128'h0);
        chk("rst_err", {127'h0, error_o}, 128'h0);
        rst_n = 1'b1;
        tick(2);

        // Nominal encryption
        full_run(64'h0123_4567_89AB_CDEF, 128'hDEAD_BEEF);

        // Stall, back-pressure and spurious flags in one run
        go_pulse();
        tick(5);
        pulse_flag(4);
        send_block(64'h0123_4567_89AB_CDEF);
        tick(11);
        pulse_flag(0);
        for (int i = 0; i < 20; i++) begin
            chk("stall_dv", {127'h0, data_valid_o}, 128'h0);
            chk("stall_idx", {126'h0, blk_idx_o}, 128'd1);
            tick(1);
        end
        send_block(64'h1);
        cipher_ready_i = 1'b0;
        cipher_i = 64'hAA;
        cipher_valid_i = 1'b1;
        exp_cip_q.push_back(64'hAA);
        tick(1);
        cipher_valid_i = 1'b0;
        chk("cvalid_rise", {127'h0, cipher_valid_o}, 128'h1);
        chk("cipher_buf", {64'h0, cipher_o}, 128'hAA);
        end_c2 = 1'b1;
        tick(1);
        end_c2 = 1'b0;
        chk("spur_idx", {126'h0, blk_idx_o}, 128'd1);
        chk("spur_busy", {127'h0, busy_o}, 128'h1);
        chk("spur_ready", {127'h0, in_ready_o}, 128'h0);
        tick(3);
        pulse_flag(1);
        chk("adv_idx", {126'h0, blk_idx_o}, 128'd2);
        in_data_i = 64'h2;
        in_valid_i = 1'b1;
        exp_blk_q.push_back(64'h2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", {127'h0, in_ready_o}, 128'h0);
            chk("bp_dv", {127'h0, data_valid_o}, 128'h0);
            tick(1);
        end
        cipher_ready_i = 1'b1;
        tick(1);
        chk("bp_release", {127'h0, in_ready_o}, 128'h1);
        chk("cbuf_empty", {127'h0, cipher_valid_o}, 128'h0);
        tick(1);
        in_valid_i = 1'b0;
        chk("p2_dv", {127'h0, data_valid_o}, 128'h1);
        tick(3);

        // Asynchronous reset in WAIT_BLK with idx 2
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {127'h0, busy_o}, 128'h0);
        chk("arst_idx", {126'h0, blk_idx_o}, 128'd0);
        chk("arst_data", {64'h0, data_o}, 128'h0);
        chk("arst_cipher", {64'h0, cipher_o}, 128'h0);
        chk("arst_tag", tag_o, 128'h0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_busy", {127'h0, busy_o}, 128'h0);
        full_run(64'h5555_AAAA_5555_AAAA, 128'hCAFE_F00D);

`ifdef ASCON_FEEDER_TIMEOUT_EN
        go_pulse();
        tick(5);
        pulse_flag(4);
        send_block(64'h77);
        tick(1);
        tick(64);
        chk("wd_early", {127'h0, error_o}, 128'h0);
        tick(1);
        chk("wd_err", {127'h0, error_o}, 128'h1);
        chk("wd_busy", {127'h0, busy_o}, 128'h1);
        chk("wd_ready", {127'h0, in_ready_o}, 128'h0);
        go_pulse();
        chk("wd_clear", {127'h0, error_o}, 128'h0);
        chk("wd_idle", {127'h0, busy_o}, 128'h0);
`endif

        tick(2);
        chk("blk_q_empty", 128'(exp_blk_q.size()), 128'd0);
        chk("cip_q_empty", 128'(exp_cip_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
